// File: rtl/frame_rd_arbiter_pkg.sv
// Shared GPU types for the frame-memory read path: sizes, arbiter state encoding and core index type.
package gpu_pkg;

    localparam int FRAME_ADDR_W = 10;
    localparam int FRAME_DATA_W = 16;
    localparam int NUM_CORES    = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CAPT
    } arb_state_t;

    typedef logic [$clog2(NUM_CORES)-1:0] core_id_t;

endpackage

// File: rtl/frame_rd_arbiter_if.sv
// Requester, response and frame-memory signals of the read arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface frame_rd_arbiter_if
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = gpu_pkg::NUM_CORES,
    parameter int ADDR_W    = FRAME_ADDR_W,
    parameter int DATA_W    = FRAME_DATA_W
) ();

    logic [NUM_CORES-1:0]          core_req;
    logic [NUM_CORES*ADDR_W-1:0]   core_addr;
    logic [NUM_CORES-1:0]          core_ack;
    logic                          sched_req;
    logic [ADDR_W-1:0]             sched_addr;
    logic                          sched_ack;
    logic [2*DATA_W-1:0]           rsp_data;
    logic [$clog2(NUM_CORES)-1:0]  rsp_core;
    logic                          mem_rd_en;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_rd_data;
    logic                          busy;

    modport slave (
        input  core_req, core_addr, sched_req, sched_addr, mem_rd_data,
        output core_ack, sched_ack, rsp_data, rsp_core, mem_rd_en, mem_addr, busy
    );

    modport master (
        output core_req, core_addr, sched_req, sched_addr, mem_rd_data,
        input  core_ack, sched_ack, rsp_data, rsp_core, mem_rd_en, mem_addr, busy
    );

endinterface

// File: rtl/frame_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr+1 (wrapping),
// so the requester at ptr itself has the lowest priority.
module rr_pick #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 vld,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);

    logic [W-1:0] cand;

    // Scan from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = N; i >= 1; i--) begin
            cand = ptr + W'(i);
            if (req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/frame_rd_arbiter.sv
// Frame-memory read arbiter: scheduler strict priority, cores round-robin, two 16-bit reads per 32-bit message.
// Grant-to-ack latency 4 cycles, one message per 4 cycles; requesters wait by holding their request level.
module frame_rd_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = gpu_pkg::NUM_CORES,
    parameter int ADDR_W    = FRAME_ADDR_W,
    parameter int DATA_W    = FRAME_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    frame_rd_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_CORES);

    arb_state_t           state, next_state;
    logic [NUM_CORES-1:0] elig;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic                 grant_sched;
    logic                 grant_core;
    logic [ADDR_W-1:0]    grant_addr;
    logic [ADDR_W-1:0]    addr_q;
    logic                 owner_sched;
    logic [IDX_W-1:0]     owner_core;
    logic [DATA_W-1:0]    lo_q;

    // A requester whose ack is on the bus this cycle must not be re-granted off its stale level.
    assign elig = bus.core_req & ~bus.core_ack;

    rr_pick #(.N(NUM_CORES)) u_pick (
        .req (elig),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_comb begin
        next_state  = state;
        grant_sched = 1'b0;
        grant_core  = 1'b0;
        grant_addr  = addr_q;
        case (state)
            IDLE: begin
                if (bus.sched_req && !bus.sched_ack) begin
                    grant_sched = 1'b1;
                    grant_addr  = bus.sched_addr;
                    next_state  = RD_LO;
                end else if (pick_vld) begin
                    grant_core = 1'b1;
                    grant_addr = bus.core_addr[pick_idx*ADDR_W +: ADDR_W];
                    next_state = RD_LO;
                end
            end
            RD_LO:   next_state = RD_HI;
            RD_HI:   next_state = CAPT;
            CAPT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Memory strobe/address are registered one state ahead so they are valid during RD_LO/RD_HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '1;
            addr_q        <= '0;
            owner_sched   <= 1'b0;
            owner_core    <= '0;
            lo_q          <= '0;
            bus.core_ack  <= '0;
            bus.sched_ack <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_core  <= '0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.core_ack  <= '0;
            bus.sched_ack <= 1'b0;
            bus.busy      <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (grant_sched || grant_core) begin
                        owner_sched   <= grant_sched;
                        owner_core    <= pick_idx;
                        addr_q        <= grant_addr;
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= grant_addr;
                    end
                    if (grant_core) rr_ptr <= pick_idx;
                end
                RD_LO: begin
                    bus.mem_addr <= addr_q + 1'b1;
                end
                RD_HI: begin
                    lo_q          <= bus.mem_rd_data;
                    bus.mem_rd_en <= 1'b0;
                end
                CAPT: begin
                    bus.rsp_data <= {bus.mem_rd_data, lo_q};
                    bus.rsp_core <= owner_sched ? '0 : owner_core;
                    if (owner_sched) bus.sched_ack <= 1'b1;
                    else             bus.core_ack  <= {{(NUM_CORES-1){1'b0}}, 1'b1} << owner_core;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_rd_arbiter.sv
// Self-checking bench for frame_rd_arbiter: directed scenarios plus random requests against a transaction model.
module tb_frame_rd_arbiter;
    import gpu_pkg::*;

    localparam int NC = 16;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int SCHED_ID = NC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_rd_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    frame_rd_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Synchronous 1-cycle frame memory.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transaction-level model: one outstanding grant, its cycle, owner and expected payload.
    bit          m_valid;
    bit          m_sched;
    int          m_core;
    int          m_g;
    int          m_due;
    int          m_addr;
    logic [31:0] m_data;
    int          m_rr;
    logic [31:0] m_rsp;
    int          m_rsp_core;

    bit [NC-1:0] keep;
    bit          keep_s;
    int          obs_q[$];
    int          last_ack_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_edge();
        bit [NC-1:0] el;
        bit          s;
        bit          granted;
        int          c;
        if (rst) begin
            m_valid    = 1'b0;
            m_rr       = NC - 1;
            m_rsp      = '0;
            m_rsp_core = 0;
        end else if (!m_valid || cyc >= m_due) begin
            el      = bus.core_req;
            s       = bus.sched_req;
            granted = 1'b0;
            if (m_valid && cyc == m_due) begin
                if (m_sched) s = 1'b0;
                else         el[m_core] = 1'b0;
            end
            if (s) begin
                m_sched = 1'b1;
                m_core  = 0;
                m_addr  = int'(bus.sched_addr);
                granted = 1'b1;
            end else begin
                for (int k = 1; k <= NC; k++) begin
                    c = (m_rr + k) % NC;
                    if (el[c] && !granted) begin
                        m_sched = 1'b0;
                        m_core  = c;
                        m_addr  = int'(bus.core_addr[c*AW +: AW]);
                        m_rr    = c;
                        granted = 1'b1;
                    end
                end
            end
            if (granted) begin
                m_valid = 1'b1;
                m_g     = cyc;
                m_due   = cyc + 4;
                m_data  = {mem[(m_addr + 1) % 1024], mem[m_addr]};
            end
        end
        cyc++;
    endtask

    task automatic check_cycle();
        bit          ack_now;
        bit          rd;
        logic [NC-1:0] exp_cack;
        ack_now = m_valid && (cyc == m_due);
        if (ack_now) begin
            m_rsp      = m_data;
            m_rsp_core = m_sched ? 0 : m_core;
        end
        exp_cack = (ack_now && !m_sched) ? (NC'(1) << m_core) : '0;
        chk("core_ack",  64'(bus.core_ack),  64'(exp_cack));
        chk("sched_ack", 64'(bus.sched_ack), 64'(ack_now && m_sched));
        chk("rsp_data",  64'(bus.rsp_data),  64'(m_rsp));
        chk("rsp_core",  64'(bus.rsp_core),  64'(m_rsp_core));
        rd = m_valid && (cyc == m_g + 1 || cyc == m_g + 2);
        chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(rd));
        if (rd) chk("mem_addr", 64'(bus.mem_addr), 64'((cyc == m_g + 1) ? m_addr : (m_addr + 1) % 1024));
        chk("busy", 64'(bus.busy), 64'(m_valid && cyc > m_g && cyc < m_due));
        for (int i = 0; i < NC; i++) begin
            if (bus.core_ack[i]) begin
                obs_q.push_back(i);
                last_ack_cyc = cyc;
            end
        end
        if (bus.sched_ack) begin
            obs_q.push_back(SCHED_ID);
            last_ack_cyc = cyc;
        end
        if (ack_now) begin
            if (m_sched) begin
                if (!keep_s) bus.sched_req = 1'b0;
            end else if (!keep[m_core]) begin
                bus.core_req[m_core] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic core_raise(input int c, input logic [AW-1:0] a);
        bus.core_addr[c*AW +: AW] = a;
        bus.core_req[c] = 1'b1;
    endtask

    initial begin
        int t0;
        rst            = 1'b1;
        bus.core_req   = '0;
        bus.core_addr  = '0;
        bus.sched_req  = 1'b0;
        bus.sched_addr = '0;
        keep           = '0;
        keep_s         = 1'b0;
        m_valid        = 1'b0;
        m_rr           = NC - 1;
        m_rsp          = '0;
        m_rsp_core     = 0;
        last_ack_cyc   = -1;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

        #1;
        chk("rst_core_ack",  64'(bus.core_ack),  64'(0));
        chk("rst_sched_ack", 64'(bus.sched_ack), 64'(0));
        chk("rst_rsp_data",  64'(bus.rsp_data),  64'(0));
        chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'(0));
        chk("rst_busy",      64'(bus.busy),      64'(0));
        ticks(2);
        rst = 1'b0;

        // Single request, basic read.
        mem[10'h010] = 16'hAAAA;
        mem[10'h011] = 16'h5555;
        t0 = cyc;
        core_raise(3, 10'h010);
        ticks(5);
        chk("t1_ack_cycle", 64'(last_ack_cyc), 64'(t0 + 4));
        chk("t1_rsp_data",  64'(bus.rsp_data), 64'(32'h5555AAAA));
        chk("t1_rsp_core",  64'(bus.rsp_core), 64'(3));

        // Round-robin order from reset with all cores holding their requests.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs_q.delete();
        keep = '1;
        for (int i = 0; i < NC; i++) core_raise(i, 10'($urandom));
        ticks(70);
        keep = '0;
        bus.core_req = '0;
        chk("rr_count_ge17", 64'(obs_q.size() >= 17), 64'(1));
        for (int i = 0; i < 17 && i < obs_q.size(); i++) chk("rr_order", 64'(obs_q[i]), 64'(i % NC));
        ticks(6);

        // Address wrap past the top of memory.
        mem[10'h3FF] = 16'h1234;
        mem[10'h000] = 16'hBEEF;
        core_raise(7, 10'h3FF);
        ticks(6);
        chk("wrap_rsp_data", 64'(bus.rsp_data), 64'(32'hBEEF1234));

        // Scheduler arrives while core 2 is in RD_HI with cores 5 and 9 pending.
        obs_q.delete();
        core_raise(2, 10'($urandom));
        tick();
        tick();
        bus.sched_addr = 10'($urandom);
        bus.sched_req  = 1'b1;
        core_raise(5, 10'($urandom));
        core_raise(9, 10'($urandom));
        ticks(20);
        chk("prio_count", 64'(obs_q.size()), 64'(4));
        if (obs_q.size() == 4) begin
            chk("prio_first",  64'(obs_q[0]), 64'(2));
            chk("prio_second", 64'(obs_q[1]), 64'(SCHED_ID));
            chk("prio_third",  64'(obs_q[2]), 64'(5));
            chk("prio_fourth", 64'(obs_q[3]), 64'(9));
        end

        // Reset in RD_HI of a core 4 transaction.
        core_raise(4, 10'($urandom));
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_core_ack",  64'(bus.core_ack),  64'(0));
        chk("mid_rst_sched_ack", 64'(bus.sched_ack), 64'(0));
        chk("mid_rst_rsp_data",  64'(bus.rsp_data),  64'(0));
        chk("mid_rst_rsp_core",  64'(bus.rsp_core),  64'(0));
        chk("mid_rst_mem_rd_en", 64'(bus.mem_rd_en), 64'(0));
        chk("mid_rst_mem_addr",  64'(bus.mem_addr),  64'(0));
        chk("mid_rst_busy",      64'(bus.busy),      64'(0));
        ticks(2);
        rst = 1'b0;
        t0 = cyc;
        obs_q.delete();
        ticks(6);
        chk("mid_rst_acks", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() == 1) chk("mid_rst_who", 64'(obs_q[0]), 64'(4));
        chk("mid_rst_latency", 64'(last_ack_cyc), 64'(t0 + 4));

        // Withdrawal before grant (core 6) and after grant (core 8).
        obs_q.delete();
        core_raise(1, 10'($urandom));
        tick();
        core_raise(6, 10'($urandom));
        tick();
        bus.core_req[6] = 1'b0;
        ticks(3);
        t0 = cyc;
        core_raise(8, 10'($urandom));
        tick();
        bus.core_req[8] = 1'b0;
        ticks(5);
        chk("wd_acks", 64'(obs_q.size()), 64'(2));
        if (obs_q.size() == 2) begin
            chk("wd_first",  64'(obs_q[0]), 64'(1));
            chk("wd_second", 64'(obs_q[1]), 64'(8));
        end
        chk("wd_core8_latency", 64'(last_ack_cyc), 64'(t0 + 4));

        // Random traffic, including drops at any time.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NC; i++) begin
                if (!bus.core_req[i]) begin
                    if ($urandom_range(5) == 0) core_raise(i, 10'($urandom));
                end else if ($urandom_range(40) == 0) begin
                    bus.core_req[i] = 1'b0;
                end
            end
            if (!bus.sched_req) begin
                if ($urandom_range(15) == 0) begin
                    bus.sched_addr = 10'($urandom);
                    bus.sched_req  = 1'b1;
                end
            end else if ($urandom_range(40) == 0) begin
                bus.sched_req = 1'b0;
            end
            tick();
        end
        bus.core_req  = '0;
        bus.sched_req = 1'b0;
        ticks(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_rd_arbiter.md
# frame_rd_arbiter

Shares the single read port of the frame memory (1024 × 16-bit words) between the 16 compute cores and the scheduler. Each requester asks for one 32-bit message, formed from two consecutive 16-bit words. The block grants one requester at a time: the scheduler has strict priority, and the cores are served round-robin. It then sequences the two reads through the synchronous 1-cycle-latency memory and returns the assembled word with a one-cycle acknowledge. It sits between the frame memory and the scheduler/core message interfaces and replaces ad-hoc double-word reads.

## Interface
- NUM_CORES, 16, number of core requesters (power of two)
- ADDR_W, 10, frame-memory word address width
- DATA_W, 16, frame-memory word width; response is 2*DATA_W
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- core_req  in  NUM_CORES  per-core request level
- core_addr  in  NUM_CORES*ADDR_W  flattened low-word address per core; core i uses bits [i*ADDR_W +: ADDR_W]
- core_ack  out  NUM_CORES  one-hot, one-cycle pulse: rsp_data is valid for that core
- sched_req  in  1  scheduler request level
- sched_addr  in  ADDR_W  scheduler low-word address
- sched_ack  out  1  one-cycle pulse: rsp_data is valid for the scheduler
- rsp_data  out  2*DATA_W  {word[A+1], word[A]}
- rsp_core  out  $clog2(NUM_CORES)  index of the acked core; 0 on a scheduler ack
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  memory data; valid the cycle after mem_rd_en
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RD_LO, RD_HI, CAPT. Every transition is unconditional except the one out of IDLE.
- **IDLE**
  - The eligible set is the requests minus any requester acked in this same cycle.
  - If sched_req is eligible, grant the scheduler. Otherwise grant the first eligible core, searching upward from rr_ptr+1 modulo NUM_CORES.
  - At the clock edge, register the grant (owner, address A), update rr_ptr to the granted core (rr_ptr is unchanged on a scheduler grant), and move to RD_LO.
  - With no eligible request, remain in IDLE.
- **RD_LO**: mem_rd_en=1, mem_addr=A.
- **RD_HI**: mem_rd_en=1, mem_addr=A+1, computed modulo 2^ADDR_W (1023 wraps to 0). Latch mem_rd_data into lo_q.
- **CAPT**: mem_rd_en=0. At the edge, register rsp_data={mem_rd_data, lo_q} and rsp_core, pulse the owner's ack for the next cycle, and return to IDLE.
- Requester rules:
  - A request must be held until its ack.
  - Dropping a request before it is granted is legal.
  - Once granted, the transaction always completes and the ack still fires, even if the request has dropped.
  - core_addr and sched_addr are sampled only at the granting edge.
- Eligibility mask: the acked requester is excluded in the ack cycle. A requester that keeps its request high is re-eligible the following cycle.
- Reset, asynchronous and valid mid-transaction:
  - FSM goes to IDLE; the in-flight transaction is dropped with no ack.
  - rr_ptr=NUM_CORES-1, so core 0 has first priority.
  - All outputs go to 0: core_ack, sched_ack, rsp_data, rsp_core, mem_rd_en, mem_addr, busy.

## Timing
- A request eligible in IDLE cycle c is granted at edge c. The state sequence is RD_LO in c+1, RD_HI in c+2, CAPT in c+3, with the ack and rsp_data valid in c+4.
- rsp_data holds its value until the next CAPT. The acks are single-cycle pulses.
- The ack cycle is also an IDLE cycle, so back-to-back service runs one message every 4 cycles.
- The scheduler preempts only at grant time; it never aborts an in-flight core transaction. Worst-case scheduler wait is 3 cycles plus its own 4.
- Core starvation bound: with sched_req idle, a core waits at most (NUM_CORES-1)*4 cycles.
- All outputs are registered. No combinational path exists from any input to any output.

## Structure
- Shared package gpu_pkg holds:
  - FRAME_ADDR_W=10, FRAME_DATA_W=16, NUM_CORES=16
  - the arb_state_t enum {IDLE, RD_LO, RD_HI, CAPT}
  - the core_id_t typedef
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs are the request vector and rr_ptr; outputs are valid and index. It is reusable for the future core-done/fence tracker.

## Test plan
- Single request, basic read: mem[0x010]=0xAAAA, mem[0x011]=0x5555; core 3 requests A=0x010 in IDLE at c. Required: core_ack[3] at c+4, rsp_data=0x5555AAAA, rsp_core=3, mem_addr 0x010 then 0x011 on two consecutive cycles with mem_rd_en high.
- Round-robin order and throughput: all 16 cores request from reset. Required: acks arrive in order 0,1,…,15, one every 4 cycles. A core holding its request after its ack is next served after core 15 → core 0.
- Address wrap: core 7 requests A=0x3FF, with mem[0x3FF]=0x1234 and mem[0x000]=0xBEEF. Required: rsp_data=0xBEEF1234.
- Scheduler priority: scheduler requests while core 2 is in RD_HI and cores 5 and 9 are pending. Required: core 2 acked first, then the scheduler (sched_ack, rsp_core=0), then cores 5 and 9.
- Reset mid-transaction: assert rst in RD_HI for core 4. Required: no ack, busy=0 and all outputs 0 immediately. After release with core 4 still requesting, it is served with the full 4-cycle latency.
- Withdrawal: core 6 drops its request before grant → never acked. Core 8 drops its request the cycle after grant → core_ack[8] still fires at grant+4.
